// File: rtl/sid_bus_master.sv
// Bus initiator for a 6510-style SID bus: free-running phi2, power-up /RES,
// and one register access per phi2 period driven from a request/response port.
module sid_bus_master #(
  parameter int CLK_DIV    = 24,
  parameter int PHI2_HIGH  = 12,
  parameter int DATA_HOLD  = 1,
  parameter int RES_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [4:0] req_addr,
  input  logic [7:0] req_data,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       phi2,
  output logic [4:0] addr_o,
  output logic       r_w_n,
  output logic       cs_n,
  output logic       res_n,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int RW = $clog2(RES_CYCLES + 1);

  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - PHI2_HIGH);
  localparam logic [PW-1:0] PH_UPD  = PW'(DATA_HOLD);
  localparam logic [RW-1:0] RES_END = RW'(RES_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_IDLE,
    ST_ACCESS
  } state_t;

  state_t        state;
  logic [PW-1:0] ph;
  logic [PW-1:0] ph_next;
  logic [RW-1:0] res_cnt;
  logic          pend;
  logic          pend_we;
  logic [4:0]    pend_addr;
  logic [7:0]    pend_data;

  always_comb begin
    ph_next = (ph == PH_LAST) ? '0 : ph + 1'b1;
  end

  // Every output is registered from ph_next so it is valid in the cycle whose ph it refers to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RESET;
      ph         <= '0;
      res_cnt    <= '0;
      phi2       <= 1'b0;
      res_n      <= 1'b0;
      cs_n       <= 1'b1;
      r_w_n      <= 1'b1;
      addr_o     <= '0;
      data_o     <= '0;
      data_oe    <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      pend       <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      ph         <= ph_next;
      phi2       <= (ph_next >= PH_RISE);
      req_ready  <= (ph_next == PH_LAST) && (state != ST_RESET);
      resp_valid <= 1'b0;

      if (req_valid && req_ready) begin
        pend      <= 1'b1;
        pend_we   <= req_we;
        pend_addr <= req_addr;
        pend_data <= req_data;
      end

      case (state)
        ST_RESET: begin
          if (ph == PH_LAST) begin
            if (res_cnt == RES_END) begin
              res_n <= 1'b1;
              state <= ST_IDLE;
            end else begin
              res_cnt <= res_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (ph_next == PH_UPD) begin
            data_oe <= 1'b0;
            if (pend) begin
              addr_o <= pend_addr;
              r_w_n  <= ~pend_we;
              cs_n   <= 1'b0;
              pend   <= 1'b0;
              state  <= ST_ACCESS;
            end else begin
              cs_n  <= 1'b1;
              r_w_n <= 1'b1;
              state <= ST_IDLE;
            end
          end
          // pend_data stays valid here: the next capture can only occur after phi2 rises.
          if (ph_next == PH_RISE && state == ST_ACCESS && !r_w_n) begin
            data_o  <= pend_data;
            data_oe <= 1'b1;
          end
          if (ph == PH_LAST && state == ST_ACCESS && r_w_n) begin
            resp_data  <= data_i;
            resp_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sid_bus_master.sv
// Directed bench for sid_bus_master: phase model, read scoreboard and bus-timing checks.
module tb_sid_bus_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic [7:0] data_i = '0;
  logic       req_ready, resp_valid, phi2, r_w_n, cs_n, res_n, data_oe;
  logic [7:0] resp_data, data_o;
  logic [4:0] addr_o;

  int         checks = 0;
  int         errors = 0;
  int         tb_ph = 0;
  bit         mon_en = 1'b0;
  bit         oe_seen = 1'b0;
  bit         cs_hi_seen = 1'b0;
  logic [7:0] exp_q[$];

  sid_bus_master #(
    .CLK_DIV(24),
    .PHI2_HIGH(12),
    .DATA_HOLD(1),
    .RES_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_data(req_data),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .phi2(phi2),
    .addr_o(addr_o),
    .r_w_n(r_w_n),
    .cs_n(cs_n),
    .res_n(res_n),
    .data_o(data_o),
    .data_oe(data_oe),
    .data_i(data_i)
  );

  always #5 clk = ~clk;

  // Reference phase: 0 in the cycle after rst is sampled, then 0..23 wrapping.
  always @(posedge clk) tb_ph <= rst ? 0 : ((tb_ph == 23) ? 0 : tb_ph + 1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("phi2", phi2, (tb_ph >= 12) ? 1 : 0);
      if (tb_ph != 23) chk("ready_off_ph", req_ready, 0);
      if (data_oe === 1'b1) oe_seen = 1'b1;
      if (cs_n === 1'b1) cs_hi_seen = 1'b1;
      if (resp_valid === 1'b1) begin
        chk("resp_ph", tb_ph, 0);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL resp_unexpected observed=%0h expected=no_response", resp_data);
        end
        if (exp_q.size() != 0) chk("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_ph(input int p);
    for (int i = 0; i < 60 && tb_ph != p; i++) @(negedge clk);
    if (tb_ph != p) begin
      errors++;
      $error("FAIL wait_ph observed=%0d expected=%0d", tb_ph, p);
    end
  endtask

  task automatic accept(input bit we, input logic [4:0] a, input logic [7:0] d);
    req_we = we;
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    wait_ph(23);
    chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    int rdy;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_phi2", phi2, 0);
    chk("rst_res_n", res_n, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_r_w_n", r_w_n, 1);
    chk("rst_addr", addr_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    rst = 1'b0;
    n = 0;
    rdy = 0;
    while (res_n !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
      if (req_ready !== 1'b0) rdy++;
    end
    chk("res_len", n, 240);
    chk("res_rise_ph", tb_ph, 0);
    chk("ready_in_reset", rdy, 0);
  endtask

  initial begin
    #100000;
    $error("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    mon_en = 1'b1;
    // req_valid held from reset: must not be accepted before IDLE
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 5'h18;
    req_data = 8'h0F;
    do_reset();

    // write 0x18 <- 0x0F
    accept(1'b1, 5'h18, 8'h0F);
    @(negedge clk);
    chk("wr_cs_n", cs_n, 0);
    chk("wr_r_w_n", r_w_n, 0);
    chk("wr_addr", addr_o, 5'h18);
    chk("wr_oe_early", data_oe, 0);
    wait_ph(11);
    chk("wr_oe_pre_rise", data_oe, 0);
    @(negedge clk);
    chk("wr_oe_rise", data_oe, 1);
    chk("wr_data", data_o, 8'h0F);
    wait_ph(0);
    chk("wr_oe_hold", data_oe, 1);
    @(negedge clk);
    chk("wr_oe_end", data_oe, 0);
    chk("wr_cs_end", cs_n, 1);
    chk("wr_rw_end", r_w_n, 1);

    // read 0x1B, data valid only in the ph=23 cycle
    data_i = 8'h5A;
    oe_seen = 1'b0;
    accept(1'b0, 5'h1B, 8'hFF);
    @(negedge clk);
    chk("rd_cs_n", cs_n, 0);
    chk("rd_r_w_n", r_w_n, 1);
    chk("rd_addr", addr_o, 5'h1B);
    wait_ph(23);
    data_i = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    data_i = 8'h3C;
    chk("rd_valid", resp_valid, 1);
    @(negedge clk);
    chk("rd_valid_pulse", resp_valid, 0);
    chk("rd_data_held", resp_data, 8'hA5);
    chk("rd_no_oe", oe_seen, 0);

    // back-to-back write 0x04 then read 0x1C
    accept(1'b1, 5'h04, 8'h77);
    req_we = 1'b0;
    req_addr = 5'h1C;
    req_valid = 1'b1;
    @(negedge clk);
    chk("b2b_wr_addr", addr_o, 5'h04);
    chk("b2b_wr_rw", r_w_n, 0);
    chk("b2b_wr_cs", cs_n, 0);
    cs_hi_seen = 1'b0;
    wait_ph(23);
    chk("b2b_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_hold_addr", addr_o, 5'h04);
    chk("b2b_hold_rw", r_w_n, 0);
    chk("b2b_hold_oe", data_oe, 1);
    chk("b2b_hold_data", data_o, 8'h77);
    @(negedge clk);
    chk("b2b_rd_addr", addr_o, 5'h1C);
    chk("b2b_rd_rw", r_w_n, 1);
    chk("b2b_rd_cs", cs_n, 0);
    chk("b2b_rd_oe", data_oe, 0);
    chk("b2b_cs_cont", cs_hi_seen, 0);
    wait_ph(22);
    data_i = 8'h11;
    @(negedge clk);
    data_i = 8'hC3;
    exp_q.push_back(8'hC3);
    @(negedge clk);
    data_i = 8'h3C;
    chk("b2b_rd_valid", resp_valid, 1);
    @(negedge clk);
    chk("b2b_idle_cs", cs_n, 1);

    // reset in the middle of a write access
    accept(1'b1, 5'h0A, 8'h99);
    wait_ph(15);
    chk("abort_oe_before", data_oe, 1);
    chk("abort_cs_before", cs_n, 0);
    do_reset();

    // function restored after the second reset
    data_i = 8'h5A;
    accept(1'b0, 5'h01, 8'h00);
    wait_ph(23);
    data_i = 8'h5E;
    exp_q.push_back(8'h5E);
    @(negedge clk);
    chk("post_rd_valid", resp_valid, 1);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
